// File: rtl/led_bit_encoder.sv
// Single-wire LED bit encoder: turns {bit, valid, treset} symbols into the
// short-high / long-high / long-low pulse waveform driven onto the pad.
module led_bit_encoder #(
    parameter int CNT_W        = 13,
    parameter int T0H_CYCLES   = 40,
    parameter int T1H_CYCLES   = 80,
    parameter int BIT_CYCLES   = 125,
    parameter int RESET_CYCLES = 5000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_bit,
    input  logic i_valid,
    input  logic i_treset,
    output logic o_ready,
    output logic o_dout,
    output logic o_busy
);

    if (!(0 < T0H_CYCLES && T0H_CYCLES < T1H_CYCLES && T1H_CYCLES < BIT_CYCLES &&
          BIT_CYCLES < RESET_CYCLES && RESET_CYCLES < (2 ** CNT_W))) begin : g_bad_params
        $error("led_bit_encoder: timing parameters are inconsistent");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HIGH  = 2'd1,
        ST_LOW   = 2'd2,
        ST_RESET = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] T0H_LAST = CNT_W'(T0H_CYCLES - 1);
    localparam logic [CNT_W-1:0] T1H_LAST = CNT_W'(T1H_CYCLES - 1);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(BIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RESET_CYCLES - 1);

    state_t           state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic             bit_r, bit_s;
    logic             dout_r;
    logic             busy_r;
    logic             ready_s;
    logic             accept_s;
    logic [CNT_W-1:0] th_last_s;
    logic [CNT_W-1:0] sat_s;
    logic [CNT_W-1:0] cnt_inc_s;

    // Ready depends only on state and count, never on i_valid.
    always_comb begin
        ready_s = 1'b0;
        case (state_r)
            ST_IDLE:  ready_s = 1'b1;
            ST_LOW:   ready_s = (cnt_r == BIT_LAST);
            ST_RESET: ready_s = (cnt_r == RST_LAST);
            default:  ready_s = 1'b0;
        endcase
    end

    assign accept_s = i_valid & ready_s;

    // Saturating counter increment, terminal count chosen per state.
    always_comb begin
        th_last_s = bit_r ? T1H_LAST : T0H_LAST;
        if (state_r == ST_RESET) begin
            sat_s = RST_LAST;
        end else begin
            sat_s = BIT_LAST;
        end
        if (cnt_r == sat_s) begin
            cnt_inc_s = cnt_r;
        end else begin
            cnt_inc_s = cnt_r + CNT_ONE;
        end
    end

    // Next-state logic; an accept in the last cycle of a symbol restarts with no gap.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        bit_s   = bit_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_s = i_treset ? ST_RESET : ST_HIGH;
                    cnt_s   = CNT_ZERO;
                    bit_s   = i_bit & ~i_treset;
                end else begin
                    cnt_s = CNT_ZERO;
                end
            end
            ST_HIGH: begin
                cnt_s = cnt_inc_s;
                if (cnt_r == th_last_s) begin
                    state_s = ST_LOW;
                end else begin
                    state_s = ST_HIGH;
                end
            end
            ST_LOW, ST_RESET: begin
                if (ready_s) begin
                    if (accept_s) begin
                        state_s = i_treset ? ST_RESET : ST_HIGH;
                        cnt_s   = CNT_ZERO;
                        bit_s   = i_bit & ~i_treset;
                    end else begin
                        state_s = ST_IDLE;
                        cnt_s   = CNT_ZERO;
                    end
                end else begin
                    cnt_s = cnt_inc_s;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = CNT_ZERO;
                bit_s   = 1'b0;
            end
        endcase
    end

    // State, counter and registered line/busy outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
            bit_r   <= 1'b0;
            dout_r  <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            bit_r   <= bit_s;
            dout_r  <= (state_r == ST_HIGH);
            busy_r  <= (state_r != ST_IDLE);
        end
    end

    assign o_ready = ready_s;
    assign o_dout  = dout_r;
    assign o_busy  = busy_r;

endmodule

// File: tb/tb_led_bit_encoder.sv
// Directed self-checking bench for led_bit_encoder at default timing.
module tb_led_bit_encoder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic i_bit = 1'b0;
    logic i_valid = 1'b0;
    logic i_treset = 1'b0;
    logic o_ready;
    logic o_dout;
    logic o_busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_rise = 0;
    int rdy_cnt = 0;
    logic prev_dout = 1'b0;
    int rise_q[$];
    int width_q[$];

    led_bit_encoder dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_bit    (i_bit),
        .i_valid  (i_valid),
        .i_treset (i_treset),
        .o_ready  (o_ready),
        .o_dout   (o_dout),
        .o_busy   (o_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Line monitor: records rising-edge cycles and high widths, counts ready cycles.
    always @(negedge clk) begin
        if (o_dout && !prev_dout) begin
            rise_q.push_back(cyc);
            last_rise = cyc;
        end
        if (!o_dout && prev_dout) width_q.push_back(cyc - last_rise);
        if (o_ready) rdy_cnt = rdy_cnt + 1;
        prev_dout = o_dout;
    end

    // Called at a negedge; presents a symbol and returns at the negedge after the accepting edge e.
    task automatic accept(input logic b, input logic tr, input logic hold, output int e);
        int waited;
        waited = 0;
        i_valid = 1'b1;
        i_bit = b;
        i_treset = tr;
        while (!o_ready && waited < 6000) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (!o_ready) begin
            errors++;
            $display("FAIL accept_timeout: o_ready=%0b after %0d cycles, required 1", o_ready, waited);
            e = cyc;
        end else begin
            e = cyc + 1;
            @(negedge clk);
        end
        if (!hold) i_valid = 1'b0;
    endtask

    task automatic test_reset();
        int highs;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({o_dout, o_busy, o_ready} !== 3'b001) begin
            errors++;
            $display("FAIL reset_state: dout/busy/ready=%b required 001", {o_dout, o_busy, o_ready});
        end
        rst_n = 1'b1;
        highs = 0;
        repeat (20) begin
            @(negedge clk);
            if (o_dout !== 1'b0) highs++;
        end
        checks++;
        if (highs != 0) begin
            errors++;
            $display("FAIL reset_idle_low: %0d high cycles, required 0", highs);
        end
    endtask

    task automatic test_single_bit0();
        int e, bad, bad_busy;
        accept(1'b0, 1'b0, 1'b0, e);
        bad = 0;
        bad_busy = 0;
        for (int k = 1; k <= 130; k++) begin
            @(negedge clk);
            if (o_dout !== (k <= 40)) bad++;
            if (o_busy !== (k <= 125)) bad_busy++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bit0_wave: %0d cycles differ, required 0 (high E+1..E+40)", bad);
        end
        checks++;
        if (bad_busy != 0) begin
            errors++;
            $display("FAIL bit0_busy: %0d cycles differ, required 0 (busy until E+125)", bad_busy);
        end
    endtask

    task automatic test_stream();
        logic [23:0] data;
        logic [23:0] word;
        int e, e_first, e_prev, bad_acc, bad_rise, bad_w, exp_w;
        data = 24'hA5C3F0;
        rise_q.delete();
        width_q.delete();
        bad_acc = 0;
        e_first = 0;
        e_prev = 0;
        for (int i = 23; i >= 0; i--) begin
            accept(data[i], 1'b0, 1'b1, e);
            if (i == 23) begin
                e_first = e;
                rdy_cnt = 0;
            end else if (e - e_prev != 125) begin
                bad_acc++;
            end
            e_prev = e;
        end
        checks++;
        if (rdy_cnt != 23) begin
            errors++;
            $display("FAIL stream_ready_pulses: %0d ready cycles, required 23", rdy_cnt);
        end
        i_valid = 1'b0;
        repeat (200) @(negedge clk);
        checks++;
        if (bad_acc != 0 || e_prev - e_first != 23 * 125) begin
            errors++;
            $display("FAIL stream_accept_spacing: %0d bad gaps, span %0d, required 0 and 2875", bad_acc, e_prev - e_first);
        end
        checks++;
        if (rise_q.size() != 24 || width_q.size() != 24) begin
            errors++;
            $display("FAIL stream_pulse_count: rises=%0d widths=%0d, required 24", rise_q.size(), width_q.size());
        end else begin
            bad_rise = 0;
            bad_w = 0;
            word = 24'h000000;
            for (int i = 0; i < 24; i++) begin
                if (i > 0 && rise_q[i] - rise_q[i-1] != 125) bad_rise++;
                exp_w = data[23-i] ? 80 : 40;
                if (width_q[i] != exp_w) bad_w++;
                word = {word[22:0], (width_q[i] > 60)};
            end
            checks++;
            if (bad_rise != 0 || rise_q[0] != e_first + 1) begin
                errors++;
                $display("FAIL stream_rise_spacing: %0d bad, first at %0d, required 0 and %0d", bad_rise, rise_q[0], e_first + 1);
            end
            checks++;
            if (bad_w != 0) begin
                errors++;
                $display("FAIL stream_widths: %0d widths wrong, required 0", bad_w);
            end
            checks++;
            if (word !== 24'hA5C3F0) begin
                errors++;
                $display("FAIL stream_decode: got %h required a5c3f0", word);
            end
        end
    endtask

    task automatic test_treset();
        int e, e2, bad_d, bad_r;
        accept(1'b1, 1'b1, 1'b0, e);
        bad_d = 0;
        bad_r = 0;
        for (int k = 1; k <= 4999; k++) begin
            @(negedge clk);
            if (o_dout !== 1'b0) bad_d++;
            if (o_ready !== (k == 4999)) bad_r++;
        end
        checks++;
        if (bad_d != 0) begin
            errors++;
            $display("FAIL treset_low: %0d high cycles, required 0", bad_d);
        end
        checks++;
        if (bad_r != 0) begin
            errors++;
            $display("FAIL treset_ready: %0d cycles wrong, required 0 (ready only at last)", bad_r);
        end
        accept(1'b1, 1'b0, 1'b0, e2);
        checks++;
        if (e2 - e != 5000) begin
            errors++;
            $display("FAIL treset_next_accept: after %0d cycles, required 5000", e2 - e);
        end
        bad_d = 0;
        for (int k = 1; k <= 125; k++) begin
            @(negedge clk);
            if (o_dout !== (k <= 80)) bad_d++;
        end
        checks++;
        if (bad_d != 0) begin
            errors++;
            $display("FAIL treset_then_bit1: %0d cycles differ, required 0", bad_d);
        end
    endtask

    task automatic test_reset_mid();
        int e, bad;
        accept(1'b1, 1'b0, 1'b0, e);
        repeat (29) @(negedge clk);
        checks++;
        if (o_dout !== 1'b1) begin
            errors++;
            $display("FAIL midrst_pre_high: dout=%b required 1", o_dout);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({o_dout, o_busy, o_ready} !== 3'b001) begin
            errors++;
            $display("FAIL midrst_async: dout/busy/ready=%b required 001", {o_dout, o_busy, o_ready});
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        accept(1'b1, 1'b0, 1'b0, e);
        bad = 0;
        for (int k = 1; k <= 125; k++) begin
            @(negedge clk);
            if (o_dout !== (k <= 80)) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL midrst_full_bit1: %0d cycles differ, required 0", bad);
        end
    endtask

    task automatic test_gap();
        int e1, e2, e3, low_gap;
        repeat (5) @(negedge clk);
        rise_q.delete();
        width_q.delete();
        accept(1'b0, 1'b0, 1'b0, e1);
        repeat (325) @(negedge clk);
        checks++;
        if ({o_dout, o_busy, o_ready} !== 3'b001) begin
            errors++;
            $display("FAIL gap_idle: dout/busy/ready=%b required 001", {o_dout, o_busy, o_ready});
        end
        accept(1'b1, 1'b0, 1'b1, e2);
        accept(1'b0, 1'b0, 1'b0, e3);
        repeat (150) @(negedge clk);
        checks++;
        if (e3 - e2 != 125) begin
            errors++;
            $display("FAIL gap_period: %0d cycles, required 125", e3 - e2);
        end
        checks++;
        if (rise_q.size() != 3 || width_q.size() != 3) begin
            errors++;
            $display("FAIL gap_pulses: rises=%0d widths=%0d, required 3", rise_q.size(), width_q.size());
        end else begin
            low_gap = rise_q[1] - (rise_q[0] + width_q[0]);
            checks++;
            if (low_gap < 200 || low_gap >= 5000) begin
                errors++;
                $display("FAIL gap_low_len: %0d cycles, required 200..4999", low_gap);
            end
            checks++;
            if (width_q[0] != 40 || width_q[1] != 80 || width_q[2] != 40) begin
                errors++;
                $display("FAIL gap_widths: %0d/%0d/%0d required 40/80/40", width_q[0], width_q[1], width_q[2]);
            end
            checks++;
            if (rise_q[2] - rise_q[1] != 125 || rise_q[1] != e2 + 1) begin
                errors++;
                $display("FAIL gap_rise: spacing %0d start %0d, required 125 and %0d", rise_q[2] - rise_q[1], rise_q[1], e2 + 1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_bit0();
        test_stream();
        test_treset();
        test_reset_mid();
        test_gap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
